i2c_bus_monitor: RTL and testbench



---
 rtl/i2c_bus_monitor.sv | 166 ++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: synchronises and filters SCL/SDA, then decodes
// START/RSTART/STOP and address/data bytes into a single-entry event register.
module i2c_bus_monitor #(
    parameter int SyncStages = 2,
    parameter int FilterLen  = 2,
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [2:0]            evt_type_o,
    output logic [7:0]            evt_data_o,
    output logic                  evt_ack_o,
    output logic                  overflow_o,
    output logic                  busy_o,
    output logic [CountWidth-1:0] byte_count_o
);

    localparam logic [2:0] EvStart  = 3'd1;
    localparam logic [2:0] EvRstart = 3'd2;
    localparam logic [2:0] EvStop   = 3'd3;
    localparam logic [2:0] EvAddr   = 3'd4;
    localparam logic [2:0] EvData   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    logic [SyncStages-1:0] scl_sync, sda_sync;
    logic [FilterLen-1:0]  scl_hist, sda_hist;
    logic                  scl_f, sda_f, scl_p, sda_p;

    // Registers reset to 1 so a released bus looks idle immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
            sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
            scl_hist[0] <= scl_sync[SyncStages-1];
            sda_hist[0] <= sda_sync[SyncStages-1];
            for (int i = 1; i < FilterLen; i++) begin
                scl_hist[i] <= scl_hist[i-1];
                sda_hist[i] <= sda_hist[i-1];
            end
            // Filtered level moves only once the whole history agrees.
            if (&scl_hist)       scl_f <= 1'b1;
            else if (~|scl_hist) scl_f <= 1'b0;
            if (&sda_hist)       sda_f <= 1'b1;
            else if (~|sda_hist) sda_f <= 1'b0;
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    logic start_det, stop_det, bit_det;

    assign start_det = scl_p & scl_f & sda_p & ~sda_f;
    assign stop_det  = scl_p & scl_f & ~sda_p & sda_f;
    assign bit_det   = ~scl_p & scl_f;

    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  new_evt;
    logic [2:0]            new_type;
    logic [7:0]            new_data;
    logic                  new_ack;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        count_d   = count_q;
        new_evt   = 1'b0;
        new_type  = 3'd0;
        new_data  = 8'd0;
        new_ack   = 1'b0;
        if (!enable_i) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            new_evt   = 1'b1;
            new_type  = (state_q == S_IDLE) ? EvStart : EvRstart;
            if (state_q == S_IDLE) count_d = '0;
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            shift_d   = 8'd0;
        end else if (stop_det) begin
            new_evt   = (state_q != S_IDLE);
            new_type  = (state_q != S_IDLE) ? EvStop : 3'd0;
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            shift_d   = 8'd0;
        end else if (bit_det && state_q != S_IDLE) begin
            if (bit_cnt_q == 4'd8) begin
                // Ninth bit is the acknowledge slot; the byte is complete.
                new_evt   = 1'b1;
                new_type  = (state_q == S_ADDR) ? EvAddr : EvData;
                new_data  = shift_q;
                new_ack   = ~sda_f;
                if (state_q == S_DATA && !(&count_q))
                    count_d = count_q + CountWidth'(1);
                state_d   = S_DATA;
                bit_cnt_d = 4'd0;
            end else begin
                shift_d   = {shift_q[6:0], sda_f};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_valid_o <= 1'b0;
            evt_type_o  <= 3'd0;
            evt_data_o  <= 8'd0;
            evt_ack_o   <= 1'b0;
            overflow_o  <= 1'b0;
        end else if (new_evt) begin
            // Acceptance in the same cycle frees the slot for the new event.
            if (!evt_valid_o || evt_ready_i) begin
                evt_valid_o <= 1'b1;
                evt_type_o  <= new_type;
                evt_data_o  <= new_data;
                evt_ack_o   <= new_ack;
            end else begin
                overflow_o  <= 1'b1;
            end
        end else if (evt_valid_o && evt_ready_i) begin
            evt_valid_o <= 1'b0;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign byte_count_o = count_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: bit-banged I2C transactions, a transaction-level
// expected-event model, and a negedge collector of accepted events.
module tb_i2c_bus_monitor;

    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b1;
    logic        scl_i = 1'b1;
    logic        sda_i = 1'b1;
    logic        evt_valid_o;
    logic        evt_ready_i = 1'b1;
    logic [2:0]  evt_type_o;
    logic [7:0]  evt_data_o;
    logic        evt_ack_o;
    logic        overflow_o;
    logic        busy_o;
    logic [15:0] byte_count_o;

    int          compared = 0;
    int          mismatched = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    bit          in_txn = 1'b0;
    bit          first_byte = 1'b0;
    int          m_count = 0;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    i2c_bus_monitor dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_type_o   (evt_type_o),
        .evt_data_o   (evt_data_o),
        .evt_ack_o    (evt_ack_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o),
        .byte_count_o (byte_count_o)
    );

    // Inputs change just after posedge, so negedge sees a settled handshake.
    always @(negedge clk)
        if (!rst_i && evt_valid_o && evt_ready_i)
            got_q.push_back({evt_type_o, evt_data_o, evt_ack_o});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) evt_ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic b_start();
        sda_i = 1'b1; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_i = 1'b0; tick(Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic b_bit(input logic b);
        sda_i = b;    tick(Q);
        scl_i = 1'b1; tick(2 * Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic b_byte(input logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) b_bit(v[i]);
        b_bit(!ack);
    endtask

    task automatic b_stop();
        sda_i = 1'b0; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_i = 1'b1; tick(Q);
    endtask

    task automatic m_start();
        b_start();
        exp_q.push_back({in_txn ? 3'd2 : 3'd1, 8'd0, 1'b0});
        if (!in_txn) m_count = 0;
        in_txn = 1'b1;
        first_byte = 1'b1;
    endtask

    task automatic m_byte(input logic [7:0] v, input logic ack);
        b_byte(v, ack);
        if (in_txn) begin
            exp_q.push_back({first_byte ? 3'd4 : 3'd5, v, ack});
            if (!first_byte && m_count != 65535) m_count++;
            first_byte = 1'b0;
        end
    endtask

    task automatic m_stop();
        b_stop();
        if (in_txn) exp_q.push_back({3'd3, 8'd0, 1'b0});
        in_txn = 1'b0;
    endtask

    task automatic check_queues(input string tag);
        int n;
        check({tag, " n_events"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s evt%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valid"}, evt_valid_o, 0);
        check({tag, " type"}, evt_type_o, 0);
        check({tag, " data"}, evt_data_o, 0);
        check({tag, " ack"}, evt_ack_o, 0);
        check({tag, " overflow"}, overflow_o, 0);
        check({tag, " busy"}, busy_o, 0);
        check({tag, " count"}, byte_count_o, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        in_txn = 1'b0;
        m_count = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        check_reset_outputs("reset");

        // Write 0xA4 acked, data 0x3C acked, STOP
        m_start();
        m_byte(8'hA4, 1'b1);
        check("t1 busy_mid", busy_o, 1);
        m_byte(8'h3C, 1'b1);
        m_stop();
        tick(10);
        check_queues("t1");
        check("t1 count", byte_count_o, 1);
        check("t1 busy_end", busy_o, 0);

        // Same transaction with RSTART and NACKed 0xA5
        m_start();
        m_byte(8'hA4, 1'b1);
        m_byte(8'h3C, 1'b1);
        m_start();
        m_byte(8'hA5, 1'b0);
        m_stop();
        tick(10);
        check_queues("t2");
        check("t2 count_kept", byte_count_o, 1);
        m_start();
        tick(10);
        check("t2 count_clear", byte_count_o, 0);
        m_stop();
        tick(10);
        check_queues("t2b");

        // START latency, then STOP while idle
        sda_i = 1'b0;
        tick(5);
        check("lat early", evt_valid_o, 0);
        tick(1);
        check("lat valid", evt_valid_o, 1);
        check("lat type", evt_type_o, 1);
        exp_q.push_back({3'd1, 8'd0, 1'b0});
        in_txn = 1'b1;
        first_byte = 1'b1;
        scl_i = 1'b0; tick(Q);
        m_stop();
        scl_i = 1'b0; tick(Q);
        sda_i = 1'b0; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_i = 1'b1; tick(10);
        check_queues("lat");
        check("idle_stop busy", busy_o, 0);

        // Backpressure: START held, ADDR dropped
        evt_ready_i = 1'b0;
        b_start();
        b_byte(8'h5A, 1'b1);
        tick(10);
        check("bp valid", evt_valid_o, 1);
        check("bp type", evt_type_o, 1);
        check("bp data", evt_data_o, 0);
        check("bp ack", evt_ack_o, 0);
        check("bp overflow", overflow_o, 1);
        check("bp n_collected", got_q.size(), 0);
        evt_ready_i = 1'b1;
        tick(1);
        evt_ready_i = 1'b0;
        check("bp drained", evt_valid_o, 0);
        exp_q.push_back({3'd1, 8'd0, 1'b0});
        in_txn = 1'b1;
        first_byte = 1'b0;
        evt_ready_i = 1'b1;
        m_stop();
        tick(10);
        check_queues("bp");
        check("bp overflow_sticky", overflow_o, 1);

        // One-cycle SDA glitch while SCL high
        do_reset();
        sda_i = 1'b0;
        tick(1);
        sda_i = 1'b1;
        tick(12);
        check("glitch busy", busy_o, 0);
        check("glitch valid", evt_valid_o, 0);
        check_queues("glitch");

        // Reset after 4 address bits, then a full transaction
        m_start();
        for (int i = 0; i < 4; i++) b_bit(1'($urandom_range(0, 1)));
        tick(2);
        check("rst_mid busy", busy_o, 1);
        check_queues("rst_pre");
        do_reset();
        check_reset_outputs("rst_mid");
        m_start();
        m_byte(8'h90, 1'b1);
        m_byte(8'hE7, 1'b0);
        m_byte(8'h01, 1'b1);
        m_stop();
        tick(10);
        check_queues("rst_post");
        check("rst_post count", byte_count_o, 2);

        // Disabled decode, and re-enable in mid-transaction
        enable_i = 1'b0;
        b_start();
        b_byte(8'h33, 1'b1);
        b_stop();
        tick(10);
        check("dis busy", busy_o, 0);
        enable_i = 1'b0;
        b_start();
        enable_i = 1'b1;
        b_byte(8'h44, 1'b1);
        b_stop();
        tick(10);
        check_queues("dis");

        // Randomized transactions with random backpressure
        do_reset();
        rand_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int nb;
            m_start();
            m_byte(8'($urandom), 1'($urandom_range(0, 1)));
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) m_byte(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                m_start();
                m_byte(8'($urandom), 1'($urandom_range(0, 1)));
                m_byte(8'($urandom), 1'($urandom_range(0, 1)));
            end
            m_stop();
        end
        rand_ready = 1'b0;
        evt_ready_i = 1'b1;
        tick(20);
        check_queues("rand");
        check("rand count", byte_count_o, m_count);
        check("rand overflow", overflow_o, 0);
        check("rand busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
